// File: rtl/piezo_sched.sv
// rtl/piezo_sched.sv - arbitration and sequencing of buzzer tunes onto one shared tune player
// Fault alarm (2) outranks fanfare (1) outranks beep (0); a pending fault cuts a lower tune short.
module piezo_sched #(
   parameter logic [23:0] GAP_CYCLES = 24'h100000,
   parameter bit          FAST_SIM   = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] req,
   input  logic       mute,
   input  logic       tune_busy,
   output logic       go,
   output logic [1:0] tune_sel,
   output logic       abort,
   output logic [2:0] pending,
   output logic       busy,
   output logic       drop
);

   localparam logic [23:0] GAP_STEP = FAST_SIM ? 24'd16 : 24'd1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_ACK,
      S_PLAY,
      S_GAP
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  pending_q, pending_d;
   logic [1:0]  sel_q, sel_d;
   logic [2:0]  ack_cnt_q, ack_cnt_d;
   logic [23:0] gap_cnt_q, gap_cnt_d;
   logic        abort_q, abort_d;
   logic        drop_q, drop_d;
   logic [24:0] gap_sum;
   logic        preempt;

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      sel_d     = sel_q;
      ack_cnt_d = ack_cnt_q;
      gap_cnt_d = gap_cnt_q;
      abort_d   = 1'b0;
      drop_d    = 1'b0;
      gap_sum   = {1'b0, gap_cnt_q} + {1'b0, GAP_STEP};
      preempt   = mute || (pending_q[2] && (sel_q != 2'd2));

      case (state_q)
         S_IDLE: begin
            if ((pending_q != 3'b000) && !mute) begin
               if (pending_q[2])      sel_d = 2'd2;
               else if (pending_q[1]) sel_d = 2'd1;
               else                   sel_d = 2'd0;
               state_d = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            pending_d = pending_q & ~(3'b001 << sel_q);
            ack_cnt_d = 3'd0;
            state_d   = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (tune_busy) begin
               state_d = S_PLAY;
            end else if (ack_cnt_q == 3'd7) begin
               // eighth silent cycle: the launch is abandoned, not re-queued
               drop_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               ack_cnt_d = ack_cnt_q + 3'd1;
            end
         end
         S_PLAY: begin
            gap_cnt_d = 24'd0;
            if (preempt) begin
               abort_d = 1'b1;
               state_d = S_GAP;
            end else if (!tune_busy) begin
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (gap_cnt_q >= GAP_CYCLES) begin
               state_d = S_IDLE;
            end else begin
               gap_cnt_d = gap_sum[24] ? 24'hFFFFFF : gap_sum[23:0];
            end
         end
         default: state_d = S_IDLE;
      endcase

      // a new request beats the launch-cycle clear of the same bit
      pending_d = mute ? 3'b000 : (pending_d | req);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pending_q <= 3'b000;
         sel_q     <= 2'd0;
         ack_cnt_q <= 3'd0;
         gap_cnt_q <= 24'd0;
         abort_q   <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         sel_q     <= sel_d;
         ack_cnt_q <= ack_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         abort_q   <= abort_d;
         drop_q    <= drop_d;
      end
   end

   assign go       = (state_q == S_LAUNCH);
   assign busy     = (state_q != S_IDLE);
   assign tune_sel = sel_q;
   assign abort    = abort_q;
   assign drop     = drop_q;
   assign pending  = pending_q;

endmodule

// File: tb/tb_piezo_sched.sv
// tb/tb_piezo_sched.sv - directed bench for piezo_sched with a timer-based reference model
// A small player stand-in answers go with tune_busy for play_len cycles.
module tb_piezo_sched;

   localparam logic [23:0] GAP  = 24'd64;
   localparam int          STEP = 16;

   localparam int P_IDLE   = 0;
   localparam int P_LAUNCH = 1;
   localparam int P_WAIT   = 2;
   localparam int P_PLAY   = 3;
   localparam int P_GAP    = 4;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic [2:0] req       = 3'b000;
   logic       mute      = 1'b0;
   logic       tune_busy = 1'b0;
   logic       go;
   logic [1:0] tune_sel;
   logic       abort;
   logic [2:0] pending;
   logic       busy;
   logic       drop;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   piezo_sched #(.GAP_CYCLES(GAP), .FAST_SIM(1'b1)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req(req),
      .mute(mute),
      .tune_busy(tune_busy),
      .go(go),
      .tune_sel(tune_sel),
      .abort(abort),
      .pending(pending),
      .busy(busy),
      .drop(drop)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // reference model: phases with countdown timers
   int         m_phase     = P_IDLE;
   logic [2:0] m_pend      = 3'b000;
   int         m_sel       = 0;
   int         m_wait_left = 0;
   int         m_gap_left  = 0;
   bit         m_abort     = 1'b0;
   bit         m_drop      = 1'b0;

   function automatic int top_index(input logic [2:0] p);
      for (int i = 2; i >= 0; i--) if (p[i]) return i;
      return 0;
   endfunction

   task automatic model_reset();
      m_phase = P_IDLE; m_pend = 3'b000; m_sel = 0;
      m_wait_left = 0; m_gap_left = 0; m_abort = 1'b0; m_drop = 1'b0;
   endtask

   task automatic model_step();
      int         nxt_phase = m_phase;
      logic [2:0] nxt_pend  = m_pend;
      bit         nxt_abort = 1'b0;
      bit         nxt_drop  = 1'b0;
      case (m_phase)
         P_IDLE: if (!mute && m_pend != 3'b000) begin
            m_sel = top_index(m_pend);
            nxt_phase = P_LAUNCH;
         end
         P_LAUNCH: begin
            nxt_pend[m_sel] = 1'b0;
            m_wait_left = 8;
            nxt_phase = P_WAIT;
         end
         P_WAIT: begin
            if (tune_busy) nxt_phase = P_PLAY;
            else if (m_wait_left == 1) begin nxt_drop = 1'b1; nxt_phase = P_IDLE; end
            else m_wait_left--;
         end
         P_PLAY: begin
            if (mute || (m_pend[2] && m_sel != 2)) begin
               nxt_abort = 1'b1; nxt_phase = P_GAP;
            end else if (!tune_busy) nxt_phase = P_GAP;
            if (nxt_phase == P_GAP) m_gap_left = (int'(GAP) + STEP - 1) / STEP;
         end
         P_GAP: begin
            if (m_gap_left == 0) nxt_phase = P_IDLE;
            else m_gap_left--;
         end
         default: nxt_phase = P_IDLE;
      endcase
      if (mute) nxt_pend = 3'b000;
      else      nxt_pend = nxt_pend | req;
      m_phase = nxt_phase; m_pend = nxt_pend; m_abort = nxt_abort; m_drop = nxt_drop;
   endtask

   always @(posedge clk) begin
      if (!rst_n) model_reset();
      else        model_step();
   end
   always @(negedge rst_n) model_reset();

   always @(negedge clk) begin
      chk("go", go, m_phase == P_LAUNCH);
      chk("busy", busy, m_phase != P_IDLE);
      chk("tune_sel", tune_sel, m_sel);
      chk("pending", pending, m_pend);
      chk("abort", abort, m_abort);
      chk("drop", drop, m_drop);
   end

   // tune player stand-in
   bit ack_en   = 1'b1;
   int play_len = 100;
   int p_cnt    = 0;
   bit p_go, p_ab;
   always begin
      @(negedge clk);
      p_go = go; p_ab = abort;
      @(posedge clk); #1;
      if (!rst_n) begin p_cnt = 0; tune_busy = 1'b0; end
      else if (p_go && ack_en) begin p_cnt = play_len; tune_busy = 1'b1; end
      else if (p_ab) begin p_cnt = 0; tune_busy = 1'b0; end
      else if (p_cnt > 0) begin p_cnt--; tune_busy = (p_cnt != 0); end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic pulse_req(input logic [2:0] v);
      req = v; tick(); req = 3'b000;
   endtask

   task automatic wait_go(input int limit);
      int n = 0;
      while (!go && n < limit) begin tick(); n++; end
      chk("go_seen", go, 1);
   endtask

   task automatic wait_idle(input int limit, output int n_abort);
      int n = 0;
      n_abort = 0;
      while (busy && n < limit) begin tick(); n++; if (abort) n_abort++; end
      chk("idle_seen", busy, 0);
   endtask

   task automatic count_go(input int cycles, output int n_go);
      n_go = 0;
      repeat (cycles) begin tick(); if (go) n_go++; end
   endtask

   initial begin
      int c0, n, na;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (3) tick();

      // single beep: latency and total busy span (7 + play_len with a 5-cycle gap)
      play_len = 100;
      c0 = cyc;
      pulse_req(3'b001);
      wait_go(10);
      chk("s1_latency", cyc - c0, 2);
      chk("s1_sel", tune_sel, 0);
      chk("s1_busy", busy, 1);
      c0 = cyc;
      wait_idle(400, na);
      chk("s1_busy_cycles", cyc - c0, 107);

      // request coinciding with its own launch stays pending
      play_len = 5;
      pulse_req(3'b001);
      wait_go(10);
      pulse_req(3'b001);
      chk("s6_set_wins", pending, 3'b001);
      wait_go(100);
      chk("s6_relaunch_sel", tune_sel, 0);
      wait_idle(100, na);

      // simultaneous fanfare + beep
      play_len = 10;
      pulse_req(3'b011);
      chk("s2_pend_011", pending, 3'b011);
      wait_go(10);
      chk("s2_first_sel", tune_sel, 1);
      tick();
      chk("s2_pend_001", pending, 3'b001);
      wait_go(100);
      chk("s2_second_sel", tune_sel, 0);
      tick();
      chk("s2_pend_000", pending, 3'b000);
      wait_idle(100, na);

      // fault preempts a beep; a fault during the fault tune does not abort
      play_len = 40;
      pulse_req(3'b001);
      wait_go(10);
      repeat (5) tick();
      pulse_req(3'b100);
      chk("s3_abort_early", abort, 0);
      tick();
      chk("s3_abort", abort, 1);
      wait_go(100);
      chk("s3_fault_sel", tune_sel, 2);
      repeat (5) tick();
      pulse_req(3'b100);
      wait_idle(200, na);
      chk("s3_no_abort", na, 0);
      wait_go(10);
      chk("s3_refault_sel", tune_sel, 2);
      wait_idle(200, na);

      // no acknowledge from the player
      ack_en = 1'b0;
      pulse_req(3'b001);
      wait_go(10);
      c0 = cyc; n = 0;
      while (!drop && n < 20) begin tick(); n++; end
      chk("s4_drop_seen", drop, 1);
      chk("s4_drop_delay", cyc - c0, 9);
      chk("s4_busy", busy, 0);
      chk("s4_pending", pending, 3'b000);
      ack_en = 1'b1;
      repeat (3) tick();

      // mute during fanfare, requests while muted, then unmute
      play_len = 50;
      pulse_req(3'b010);
      wait_go(10);
      repeat (5) tick();
      mute = 1'b1;
      tick();
      chk("s5_abort", abort, 1);
      pulse_req(3'b111);
      pulse_req(3'b011);
      chk("s5_pend_muted", pending, 3'b000);
      count_go(30, n);
      chk("s5_no_go_muted", n, 0);
      mute = 1'b0;
      count_go(20, n);
      chk("s5_no_go_unmuted", n, 0);
      chk("s5_idle", busy, 0);

      // reset mid-tune
      play_len = 50;
      pulse_req(3'b100);
      wait_go(10);
      repeat (5) tick();
      pulse_req(3'b001);
      chk("s7_pend_before", pending, 3'b001);
      chk("s7_sel_before", tune_sel, 2);
      rst_n = 1'b0;
      #1;
      chk("s7_go", go, 0);
      chk("s7_abort", abort, 0);
      chk("s7_drop", drop, 0);
      chk("s7_busy", busy, 0);
      chk("s7_sel", tune_sel, 0);
      chk("s7_pending", pending, 0);
      tick(); tick();
      rst_n = 1'b1;
      count_go(20, n);
      chk("s7_no_go_after", n, 0);
      pulse_req(3'b001);
      wait_go(10);
      chk("s7_new_sel", tune_sel, 0);
      wait_idle(200, na);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
      $fatal(1);
   end

endmodule
